// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
//   Shared types and constants for the push-button debouncer.
//   - state_e         : per-channel debounce state (STABLE, CONFIRM)
//   - DEFAULT_*       : default parameter values for the top level
//   - cnt_width()     : width of the per-channel confirm counter
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } state_e;

  // 20 ms at 50 MHz.
  localparam int   DEFAULT_STABLE_CYCLES = 1000000;
  // Keys are active-low: released level is high.
  localparam logic DEFAULT_IDLE_LEVEL    = 1'b1;

  // The counter must be able to hold STABLE_CYCLES-1; sizing it for
  // STABLE_CYCLES+1 values keeps the result at least one bit wide.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: 2-flop synchronizer followed by a STABLE/CONFIRM FSM.
//   The output follows the synchronized input only after the new level has
//   been seen for STABLE_CYCLES consecutive clocks; shorter excursions are
//   discarded.
//
//   Optional feature macro: BUTTON_DEBOUNCER_PULSE_EN (adds rise_o).
//
//   Ports
//     clk      in   system clock
//     reset    in   synchronous, active-high reset
//     raw_i    in   asynchronous raw key level
//     clean_o  out  debounced level (registered)
//     rise_o   out  [PULSE_EN only] clean_o will move idle -> active on the
//                   next clock edge (combinational, for a registered pulse)
// -----------------------------------------------------------------------------
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic IDLE_LEVEL    = DEFAULT_IDLE_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
`ifdef BUTTON_DEBOUNCER_PULSE_EN
  output logic rise_o,
`endif
  output logic clean_o
);

  localparam int            CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          out_q,   out_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; this is what makes sync1 -> sync2 a real
  // two-stage shift instead of a single wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      state_q <= STABLE;
      cnt_q   <= '0;
      out_q   <= IDLE_LEVEL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // NOTE: every variable gets a hold-value default before the case so no
  // branch leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      STABLE: begin
        if (sync2_q != out_q) begin
          if (STABLE_CYCLES == 1) begin
            // One clock of agreement is all that is required.
            out_d = sync2_q;
          end else begin
            cnt_d   = CW'(1);
            state_d = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (sync2_q == out_q) begin
          // Input fell back before qualifying: glitch rejected.
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt_q == CNT_MAX) begin
          out_d   = sync2_q;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = STABLE;
      end
    endcase
  end

  assign clean_o = out_q;

`ifdef BUTTON_DEBOUNCER_PULSE_EN
  assign rise_o = (out_q == IDLE_LEVEL) && (out_d != IDLE_LEVEL);
`endif

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Conditions the raw push-button inputs feeding the button PIO in_port.
//   Each of WIDTH channels is synchronized and debounced independently;
//   output polarity matches input polarity.
//
//   Optional feature macro: BUTTON_DEBOUNCER_PULSE_EN
//     adds press_pulse, a registered one-cycle strobe per channel on the same
//     edge that buttons_clean[i] moves from IDLE_LEVEL to ~IDLE_LEVEL.
//
//   Ports
//     clk            in   system clock (sole clock)
//     reset          in   synchronous, active-high reset
//     buttons_raw    in   [WIDTH] asynchronous raw key levels
//     press_pulse    out  [WIDTH] press strobes (PULSE_EN builds only)
//     buttons_clean  out  [WIDTH] debounced levels, straight from registers
// -----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int   WIDTH         = 4,
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic IDLE_LEVEL    = DEFAULT_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_raw,
`ifdef BUTTON_DEBOUNCER_PULSE_EN
  output logic [WIDTH-1:0] press_pulse,
`endif
  output logic [WIDTH-1:0] buttons_clean
);

`ifdef BUTTON_DEBOUNCER_PULSE_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] press_pulse_q;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .IDLE_LEVEL    (IDLE_LEVEL)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (buttons_raw[i]),
`ifdef BUTTON_DEBOUNCER_PULSE_EN
      .rise_o  (rise[i]),
`endif
      .clean_o (buttons_clean[i])
    );
  end

`ifdef BUTTON_DEBOUNCER_PULSE_EN
  // rise is the channel's next-state transition, so registering it lands the
  // pulse on the same edge the clean output changes.
  always_ff @(posedge clk) begin
    if (reset) press_pulse_q <= '0;
    else       press_pulse_q <= rise;
  end

  assign press_pulse = press_pulse_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Self-checking bench for button_debouncer (WIDTH=4, STABLE_CYCLES=8,
//   IDLE_LEVEL=1). Each scenario pushes the expected output transitions
//   (edge number and new value) to a scoreboard queue as it drives the raw
//   keys; a monitor pops and compares whenever buttons_clean changes.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int   WIDTH  = 4;
  localparam int   STABLE = 8;
  localparam int   LAT    = STABLE + 2;  // edges from raw change to output

  typedef struct {
    int         edge_n;
    logic [3:0] val;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] buttons_raw;
  logic [WIDTH-1:0] buttons_clean;
`ifdef BUTTON_DEBOUNCER_PULSE_EN
  logic [WIDTH-1:0] press_pulse;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 0;
  exp_t sb[$];
  logic [WIDTH-1:0] prev_clean;

  button_debouncer #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE),
    .IDLE_LEVEL    (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons_raw   (buttons_raw),
`ifdef BUTTON_DEBOUNCER_PULSE_EN
    .press_pulse   (press_pulse),
`endif
    .buttons_clean (buttons_clean)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: cyc holds the number of the most recent rising edge.
  always @(posedge clk) cyc++;

  // Scoreboard monitor: every output change must match the next expectation.
  always @(negedge clk) begin
    if (mon_en && (buttons_clean !== prev_clean)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change edge=%0d got=%h prev=%h",
                 cyc, buttons_clean, prev_clean);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc !== e.edge_n || buttons_clean !== e.val) begin
          errors++;
          $display("FAIL transition got edge=%0d val=%h expected edge=%0d val=%h",
                   cyc, buttons_clean, e.edge_n, e.val);
        end
      end
    end
    prev_clean = buttons_clean;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int edge_n, input logic [3:0] val);
    exp_t e;
    e.edge_n = edge_n;
    e.val    = val;
    sb.push_back(e);
  endtask

  // Closes a scenario: all expected transitions seen, steady value correct.
  task automatic finish_scenario(input string name, input logic [3:0] steady);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got pending=%0d expected pending=0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (buttons_clean !== steady) begin
      errors++;
      $display("FAIL %s_steady got=%h expected=%h", name, buttons_clean, steady);
    end
  endtask

  task automatic test_reset;
    buttons_raw = 4'hF;
    reset       = 1'b1;
    tick(3);
    reset = 1'b0;
    checks++;
    if (buttons_clean !== 4'hF) begin
      errors++;
      $display("FAIL reset_value got=%h expected=%h", buttons_clean, 4'hF);
    end
    prev_clean = buttons_clean;
    mon_en     = 1'b1;
    tick(20);
    finish_scenario("reset_idle", 4'hF);
  endtask

  task automatic test_hold;
    buttons_raw[0] = 1'b0;
    expect_at(cyc + LAT, 4'hE);
    tick(LAT + 10);
    finish_scenario("hold_press", 4'hE);
    buttons_raw[0] = 1'b1;
    expect_at(cyc + LAT, 4'hF);
    tick(LAT + 10);
    finish_scenario("hold_release", 4'hF);
  endtask

  task automatic test_glitch;
    buttons_raw[1] = 1'b0;
    tick(5);
    buttons_raw[1] = 1'b1;
    tick(25);
    finish_scenario("glitch", 4'hF);
  endtask

  task automatic test_bounce;
    buttons_raw[2] = 1'b0;
    tick(3);
    buttons_raw[2] = 1'b1;
    tick(1);
    buttons_raw[2] = 1'b0;
    expect_at(cyc + LAT, 4'hB);
    tick(LAT + 10);
    finish_scenario("bounce_press", 4'hB);
    buttons_raw[2] = 1'b1;
    expect_at(cyc + LAT, 4'hF);
    tick(LAT + 10);
    finish_scenario("bounce_release", 4'hF);
  endtask

  task automatic test_reset_mid_confirm;
    buttons_raw[3] = 1'b0;
    tick(6);                       // CONFIRM entered on edge +3, now 4 deep
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (buttons_clean !== 4'hF) begin
      errors++;
      $display("FAIL reset_mid_confirm got=%h expected=%h", buttons_clean, 4'hF);
    end
    expect_at(cyc + LAT, 4'h7);
    tick(LAT + 10);
    finish_scenario("requalify", 4'h7);
    buttons_raw[3] = 1'b1;
    expect_at(cyc + LAT, 4'hF);
    tick(LAT + 10);
    finish_scenario("requalify_release", 4'hF);
  endtask

  task automatic test_back_to_back;
    buttons_raw = 4'h0;
    expect_at(cyc + LAT, 4'h0);
    tick(LAT + 5);
    finish_scenario("all_press", 4'h0);
    buttons_raw = 4'hF;
    expect_at(cyc + LAT, 4'hF);
    tick(LAT + 5);
    finish_scenario("all_release", 4'hF);
  endtask

`ifdef BUTTON_DEBOUNCER_PULSE_EN
  task automatic test_pulse;
    int n_press;
    int n_release;
    int p_edge;
    int want;
    n_press   = 0;
    n_release = 0;
    p_edge    = -1;
    buttons_raw[0] = 1'b0;
    want = cyc + LAT;
    expect_at(want, 4'hE);
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (press_pulse[0] === 1'b1) begin
        n_press++;
        p_edge = cyc;
      end
    end
    checks++;
    if (n_press != 1 || p_edge != want) begin
      errors++;
      $display("FAIL press_pulse got count=%0d edge=%0d expected count=1 edge=%0d",
               n_press, p_edge, want);
    end
    buttons_raw[0] = 1'b1;
    expect_at(cyc + LAT, 4'hF);
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (press_pulse !== 4'h0) n_release++;
    end
    checks++;
    if (n_release != 0) begin
      errors++;
      $display("FAIL release_pulse got count=%0d expected count=0", n_release);
    end
    finish_scenario("pulse", 4'hF);
  endtask
`endif

  initial begin
    reset       = 1'b1;
    buttons_raw = 4'hF;
    prev_clean  = 'x;
    @(negedge clk);
    test_reset();
    test_hold();
    test_glitch();
    test_bounce();
    test_reset_mid_confirm();
    test_back_to_back();
`ifdef BUTTON_DEBOUNCER_PULSE_EN
    test_pulse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
